branch_squash_ctrl: RTL

- Collects branch writeback from all BJU pipes, keeps the oldest mispredicted branch, and fires one squash when the ROB commits that branch.
- Sits between the int exec block's branch writeback ports and ROB/rename/fetch.
- After each squash, runs a fixed-length recovery window that stalls rename/dispatch while spec state is restored to arch state.

---
 rtl/branch_squash_ctrl_pkg.sv | 45 ++++
 rtl/branch_squash_ctrl_oldest_sel.sv | 29 ++
 rtl/branch_squash_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/branch_squash_ctrl_pkg.sv
// rtl/branch_squash_ctrl_pkg.sv - shared types, defaults and ROB age compare for the branch squash controller
package branch_squash_ctrl_pkg;

    localparam int ROB_IDX_W           = 7;
    localparam int ROB_PTR_W           = ROB_IDX_W - 1;
    localparam int FTQ_IDX_W           = 6;
    localparam int PC_W                = 32;
    localparam int RECOVER_CYC_DEFAULT = 3;
    localparam int CNT_W               = 4;

    typedef logic [ROB_IDX_W-1:0] robIdx_t;
    typedef logic [FTQ_IDX_W-1:0] ftqIdx_t;
    typedef logic [PC_W-1:0]      pc_t;

    typedef enum logic [1:0] {
        SC_IDLE    = 2'd0,
        SC_PEND    = 2'd1,
        SC_SQUASH  = 2'd2,
        SC_RECOVER = 2'd3
    } squashCtrlState_e;

    typedef struct packed {
        robIdx_t rob_idx;
        ftqIdx_t ftq_idx;
        logic    has_mispred;
        logic    branch_taken;
        pc_t     target_pc;
        pc_t     branch_npc;
    } branchwbInfo_t;

    typedef struct packed {
        logic due_to_branch;
        logic branch_taken;
        pc_t  arch_pc;
    } squashInfo_t;

    // MSB is the wrap flag: differing flags mean the larger index was allocated first.
    function automatic logic rob_is_older(input robIdx_t a, input robIdx_t b);
        logic same_flag;
        same_flag = (a[ROB_IDX_W-1] == b[ROB_IDX_W-1]);
        return (same_flag  && (a[ROB_PTR_W-1:0] < b[ROB_PTR_W-1:0])) ||
               (!same_flag && (a[ROB_PTR_W-1:0] > b[ROB_PTR_W-1:0]));
    endfunction

endpackage

// File: rtl/branch_squash_ctrl_oldest_sel.sv
// rtl/branch_squash_ctrl_oldest_sel.sv - combinational oldest-mispredict picker across branch writeback ports
module branch_oldest_sel
    import branch_squash_ctrl_pkg::*;
#(
    parameter int NUM_BRU = 2,
    parameter int SEL_W   = (NUM_BRU > 1) ? $clog2(NUM_BRU) : 1
) (
    input  logic [NUM_BRU-1:0] i_vld,
    input  robIdx_t            i_rob_idx [NUM_BRU],
    output logic               o_vld,
    output logic [SEL_W-1:0]   o_idx
);

    robIdx_t best_rob;

    always_comb begin
        o_vld    = 1'b0;
        o_idx    = '0;
        best_rob = '0;
        for (int i = 0; i < NUM_BRU; i++) begin
            if (i_vld[i] && (!o_vld || rob_is_older(i_rob_idx[i], best_rob))) begin
                o_vld    = 1'b1;
                o_idx    = SEL_W'(i);
                best_rob = i_rob_idx[i];
            end
        end
    end

endmodule

// File: rtl/branch_squash_ctrl.sv
// rtl/branch_squash_ctrl.sv - holds oldest mispredicted branch, squashes on its commit, then stalls for recovery
// Optional perf counters: BRANCH_SQUASH_PERF_EN
module branch_squash_ctrl
    import branch_squash_ctrl_pkg::*;
#(
    parameter int NUM_BRU     = 2,
    parameter int RECOVER_CYC = RECOVER_CYC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BRU-1:0]  i_bwb_vld,
    input  branchwbInfo_t       i_bwb_info [NUM_BRU],
    input  logic                i_commit_vld,
    input  robIdx_t             i_commit_rob_idx,
    input  logic                i_ext_flush,
    output logic                o_squash_vld,
    output squashInfo_t         o_squash_info,
    output ftqIdx_t             o_squash_ftq_idx,
    output logic                o_stall,
`ifdef BRANCH_SQUASH_PERF_EN
    output logic [31:0]         o_perf_squash_cnt,
    output logic [31:0]         o_perf_replace_cnt,
    output logic [31:0]         o_perf_stall_cnt,
`endif
    output logic                o_pend_vld
);

    localparam int SEL_W = (NUM_BRU > 1) ? $clog2(NUM_BRU) : 1;

    squashCtrlState_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    branchwbInfo_t    pend_q, pend_d;
    logic             squash_vld_q, squash_vld_d;
    squashInfo_t      squash_info_q, squash_info_d;
    ftqIdx_t          squash_ftq_q, squash_ftq_d;
    logic             stall_q, stall_d;
    logic             pend_vld_q, pend_vld_d;
    logic             replace;

    logic [NUM_BRU-1:0] cand_mask;
    robIdx_t            cand_rob [NUM_BRU];
    logic               cand_vld;
    logic [SEL_W-1:0]   cand_idx;
    branchwbInfo_t      cand;
    logic               commit_hit;

    always_comb begin
        for (int i = 0; i < NUM_BRU; i++) begin
            cand_mask[i] = i_bwb_vld[i] && i_bwb_info[i].has_mispred;
            cand_rob[i]  = i_bwb_info[i].rob_idx;
        end
    end

    branch_oldest_sel #(.NUM_BRU(NUM_BRU), .SEL_W(SEL_W)) u_oldest_sel (
        .i_vld     (cand_mask),
        .i_rob_idx (cand_rob),
        .o_vld     (cand_vld),
        .o_idx     (cand_idx)
    );

    assign cand       = i_bwb_info[cand_idx];
    assign commit_hit = i_commit_vld && (i_commit_rob_idx == pend_q.rob_idx);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pend_d        = pend_q;
        squash_vld_d  = 1'b0;
        squash_info_d = '0;
        squash_ftq_d  = '0;
        replace       = 1'b0;
        if (i_ext_flush) begin
            state_d = SC_IDLE;
            pend_d  = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                SC_IDLE: begin
                    if (cand_vld) begin
                        pend_d  = cand;
                        state_d = SC_PEND;
                    end
                end
                SC_PEND: begin
                    // Commit match wins over a same-cycle replacement.
                    if (commit_hit) begin
                        state_d                     = SC_SQUASH;
                        squash_vld_d                = 1'b1;
                        squash_info_d.due_to_branch = 1'b1;
                        squash_info_d.branch_taken  = pend_q.branch_taken;
                        squash_info_d.arch_pc       = pend_q.branch_taken ? pend_q.target_pc
                                                                          : pend_q.branch_npc;
                        squash_ftq_d                = pend_q.ftq_idx;
                    end else if (cand_vld && rob_is_older(cand.rob_idx, pend_q.rob_idx)) begin
                        pend_d  = cand;
                        replace = 1'b1;
                    end
                end
                SC_SQUASH: begin
                    pend_d  = '0;
                    cnt_d   = CNT_W'(RECOVER_CYC);
                    state_d = SC_RECOVER;
                end
                SC_RECOVER: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = SC_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = SC_IDLE;
            endcase
        end
        stall_d    = (state_d == SC_SQUASH) || (state_d == SC_RECOVER);
        pend_vld_d = (state_d == SC_PEND);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= SC_IDLE;
            cnt_q         <= '0;
            pend_q        <= '0;
            squash_vld_q  <= 1'b0;
            squash_info_q <= '0;
            squash_ftq_q  <= '0;
            stall_q       <= 1'b0;
            pend_vld_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pend_q        <= pend_d;
            squash_vld_q  <= squash_vld_d;
            squash_info_q <= squash_info_d;
            squash_ftq_q  <= squash_ftq_d;
            stall_q       <= stall_d;
            pend_vld_q    <= pend_vld_d;
        end
    end

    assign o_squash_vld     = squash_vld_q;
    assign o_squash_info    = squash_info_q;
    assign o_squash_ftq_idx = squash_ftq_q;
    assign o_stall          = stall_q;
    assign o_pend_vld       = pend_vld_q;

`ifdef BRANCH_SQUASH_PERF_EN
    logic [31:0] perf_squash_q, perf_squash_d;
    logic [31:0] perf_replace_q, perf_replace_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_squash_d  = perf_squash_q;
        perf_replace_d = perf_replace_q;
        perf_stall_d   = perf_stall_q;
        if ((state_q == SC_SQUASH) && (perf_squash_q != '1)) perf_squash_d  = perf_squash_q + 32'd1;
        if (replace && (perf_replace_q != '1))               perf_replace_d = perf_replace_q + 32'd1;
        if (stall_q && (perf_stall_q != '1))                 perf_stall_d   = perf_stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_squash_q  <= '0;
            perf_replace_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_squash_q  <= perf_squash_d;
            perf_replace_q <= perf_replace_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign o_perf_squash_cnt  = perf_squash_q;
    assign o_perf_replace_cnt = perf_replace_q;
    assign o_perf_stall_cnt   = perf_stall_q;
`endif

    for (genvar i = 0; i < NUM_BRU; i++) begin : g_dup_a
        for (genvar j = i + 1; j < NUM_BRU; j++) begin : g_dup_b
            a_no_dup_rob: assert property (@(posedge clk) disable iff (!rst)
                !(cand_mask[i] && cand_mask[j] && (cand_rob[i] == cand_rob[j])));
        end
    end

    a_no_older_on_commit: assert property (@(posedge clk) disable iff (!rst)
        !((state_q == SC_PEND) && !i_ext_flush && commit_hit && cand_vld &&
          rob_is_older(cand.rob_idx, pend_q.rob_idx)));

    a_pend_is_mispred: assert property (@(posedge clk) disable iff (!rst)
        (state_q == SC_PEND) |-> pend_q.has_mispred);

endmodule
